// File: rtl/debounce_pkg.sv
// Shared constants and counter-width helper for the debounce_bank slice.
package debounce_pkg;

    localparam int DEFAULT_TICK_DIV     = 100000;
    localparam int DEFAULT_STABLE_TICKS = 20;
    localparam int DEFAULT_HOLD_TICKS   = 1000;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_tick.sv
// Shared tick prescaler: one-cycle tick every TICK_DIV clocks (every cycle when TICK_DIV=1).
module debounce_tick
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic CLK100MHZ,
    input  logic rst,
    output logic tick
);

    localparam int             W    = cnt_width(TICK_DIV);
    localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button debouncer with press/release strobes; long-press hold
// strobes are built only when DEBOUNCE_HOLD_EN is defined.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEFAULT_HOLD_TICKS
) (
    input  logic                CLK100MHZ,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] rel,
    output logic [CHANNELS-1:0] hold
);

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    if (CHANNELS < 1 || TICK_DIV < 1 || STABLE_TICKS < 1 || HOLD_TICKS < 1) begin : g_param_check
        $error("debounce_bank: all parameters must be at least 1");
    end

    logic                tick;
    logic [CHANNELS-1:0] sync_a;
    logic [CHANNELS-1:0] sync_b;

    debounce_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .tick      (tick)
    );

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          lvl_r;
        logic          press_r;
        logic          rel_r;

        // Any cycle where the input agrees with the level restarts qualification.
        always_ff @(posedge CLK100MHZ or posedge rst) begin
            if (rst) begin
                cnt     <= '0;
                lvl_r   <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
            end else begin
                press_r <= 1'b0;
                rel_r   <= 1'b0;
                if (sync_b[i] == lvl_r) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        lvl_r   <= sync_b[i];
                        press_r <= sync_b[i];
                        rel_r   <= ~sync_b[i];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end

        assign level[i] = lvl_r;
        assign press[i] = press_r;
        assign rel[i]   = rel_r;

`ifdef DEBOUNCE_HOLD_EN
        localparam int            HW        = cnt_width(HOLD_TICKS);
        localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);
        localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_TICKS - 1);

        logic [HW-1:0] hcnt;
        logic          hold_r;

        // Saturating at HOLD_LAST gives one hold per press with no auto-repeat.
        always_ff @(posedge CLK100MHZ or posedge rst) begin
            if (rst) begin
                hcnt   <= '0;
                hold_r <= 1'b0;
            end else begin
                hold_r <= 1'b0;
                if (!lvl_r) begin
                    hcnt <= '0;
                end else if (tick && hcnt != HOLD_LAST) begin
                    hcnt   <= hcnt + HW'(1);
                    hold_r <= (hcnt == HOLD_PRE);
                end
            end
        end

        assign hold[i] = hold_r;
`else
        assign hold[i] = 1'b0;
`endif
    end

endmodule
